alu_serial: RTL and testbench
=============================

Name: alu_serial

Overview:
- Multi-cycle, slice-serial implementation of the 32-bit ALU command set (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR).
- Acts as the responder end of the ALU request interface: accepts one operation through a valid/ready request, processes SLICE bits per cycle from the LSB up, then returns result, carryout, zero and overflow through a valid/ready response.
- Intended for area-constrained datapaths; results are bit-identical to the combinational ALU.

Parameters:
- WIDTH, 32, operand and result width.
- SLICE, 1, bits processed per cycle. WIDTH must be an integer multiple of SLICE.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- operand_a  in  WIDTH  first operand, two's complement.
- operand_b  in  WIDTH  second operand, two's complement.
- command  in  3  operation: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
- rsp_valid  out  1  response outputs are valid.
- rsp_ready  in  1  consumer accepts the response.
- result  out  WIDTH  operation result.
- carryout  out  1  carry out of the MSB (ADD/SUB only).
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (ADD/SUB only).

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0.
  - result=0, carryout=0, zero=0, overflow=0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, DONE. req_ready=1 only in IDLE; rsp_valid=1 only in DONE.
- IDLE:
  - On req_valid at a rising edge, capture operand_a, operand_b and command.
  - Set slice counter to 0.
  - Set internal carry to 1 for SUB/SLT, else 0.
  - Go to RUN.
  - Operand or command changes after acceptance have no effect.
- RUN:
  - Each edge processes slice k (bits k*SLICE .. k*SLICE+SLICE-1) and updates the carry.
  - Shifts the slice into the result register and ORs it into a nonzero accumulator.
  - After the last slice (k = WIDTH/SLICE-1), go to DONE and load all output registers.
  - Latency: rsp_valid rises N = WIDTH/SLICE edges after the acceptance edge (32 for defaults).
- Arithmetic rules:
  - SUB is computed as a + ~b + 1.
  - carryout = final carry out of the MSB for ADD and SUB; no borrow inversion.
  - overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is b for ADD and ~b for SUB/SLT.
  - SLT: result = {0, sum[MSB] XOR overflow}, i.e. the signed a<b comparison is correct even when the subtraction overflows.
  - carryout=0 and overflow=0 for SLT and for all logical ops.
  - zero is computed on the final result for every command, SLT included.
- DONE:
  - Outputs are held stable while rsp_ready=0.
  - req_valid is ignored.
  - On rsp_ready, go to IDLE.
  - No same-cycle accept in DONE.
- Outputs hold their last values in IDLE and RUN; they are meaningful only while rsp_valid=1.
- Reset asserted in any state takes effect immediately and is not sampled on clk.

Decomposition:
- Package alu_defs holds:
  - Command encodings ADD..OR (values 0..7).
  - Default WIDTH.
  - FSM state enum {IDLE, RUN, DONE}.
- Sub-module alu_slice: combinational SLICE-bit slice. Inputs a, b, cin, command; outputs s, cout.
  - Performs the b inversion for SUB/SLT and all logical ops.
  - Instantiated once by alu_serial.

Test Plan:
- Reset mid-operation: accept ADD 2+1, drop rst_n at cycle 10 of RUN.
  - Immediately req_ready=1, rsp_valid=0, result=0, all flags 0.
  - A new request is accepted after release.
- ADD: each case gives rsp_valid exactly 32 edges after accept.
  - 2+1 -> result=3, cout=0, ovf=0, zero=0.
  - 4+(-2) -> 2, cout=1.
  - 5+(-7) -> 0xFFFFFFFE, cout=0.
  - 1+(-1) -> 0, cout=1, zero=1.
- Overflow:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1, cout=0.
  - SUB 0x80000000-1 -> 0x7FFFFFFF, ovf=1, cout=1.
  - SUB 5-5 -> 0, zero=1, cout=1.
- SLT:
  - -3<2 -> 1.
  - 0x80000000<1 -> 1 (overflow case), cout=0, ovf=0.
  - 2<-3 -> 0, zero=1.
- Logical, a=0xF0F0F0F0, b=0xFF00FF00:
  - AND -> 0xF000F000.
  - NAND -> 0x0FFF0FFF.
  - NOR -> 0x000F000F.
  - OR -> 0xFFF0FFF0.
  - XOR -> 0x0FF00FF0.
  - cout=0 and ovf=0 for all.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles in DONE with req_valid=1 and new operands applied: outputs unchanged, req_ready=0.
  - Release rsp_ready: IDLE next edge, the new request is accepted.
  - Repeat with SLICE=8: latency is 4 edges.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared definitions for the slice-serial ALU: command encodings, default
// operand width, controller states and small command-decoding helpers.
package alu_defs;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Commands that add the inverted second operand plus an initial carry of one.
    function automatic logic is_sub_like(input alu_cmd_e cmd);
        return (cmd == CMD_SUB) || (cmd == CMD_SLT);
    endfunction

    // Commands whose carry out and overflow are reported on the response.
    function automatic logic reports_flags(input alu_cmd_e cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice. Arithmetic commands ripple a carry from
// cin to cout; logical commands ignore cin and drive cout low.
module alu_slice
    import alu_defs::*;
#(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  alu_cmd_e         command,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE-1:0] b_eff_s;
    logic [SLICE:0]   total_s;

    // Slice adder on the (possibly inverted) operand plus per-command result select.
    always_comb begin
        b_eff_s = is_sub_like(command) ? ~b : b;
        total_s = {1'b0, a} + {1'b0, b_eff_s} + {{SLICE{1'b0}}, cin};
        s       = total_s[SLICE-1:0];
        cout    = 1'b0;
        case (command)
            CMD_ADD, CMD_SUB, CMD_SLT: begin
                s    = total_s[SLICE-1:0];
                cout = total_s[SLICE];
            end
            CMD_XOR:  s = a ^ b;
            CMD_AND:  s = a & b;
            CMD_NAND: s = ~(a & b);
            CMD_NOR:  s = ~(a | b);
            CMD_OR:   s = a | b;
            default: begin
                s    = total_s[SLICE-1:0];
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Slice-serial ALU responder. One request is captured in IDLE, SLICE bits are
// processed per cycle from the LSB up in RUN, and the registered result and
// flags are offered in DONE until the consumer takes them.
module alu_serial
    import alu_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [2:0]       command,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    alu_cmd_e         cmd_q, cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             nz_q, nz_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryout_q, carryout_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [SLICE-1:0] slice_sum_s;
    logic             slice_cout_s;
    logic [WIDTH-1:0] sum_full_s;
    logic             sum_msb_s;
    logic             b_prime_msb_s;
    logic             ovf_raw_s;
    logic             slt_bit_s;
    logic             nonzero_s;

    // The low SLICE bits of the shifting operand registers always hold slice k.
    alu_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a       (a_q[SLICE-1:0]),
        .b       (b_q[SLICE-1:0]),
        .cin     (carry_q),
        .command (cmd_q),
        .s       (slice_sum_s),
        .cout    (slice_cout_s)
    );

    // Final-slice view: full sum, signed overflow and the SLT bit.
    always_comb begin
        sum_full_s    = (acc_q >> SLICE) | (WIDTH'(slice_sum_s) << (WIDTH - SLICE));
        sum_msb_s     = slice_sum_s[SLICE-1];
        b_prime_msb_s = is_sub_like(cmd_q) ? ~b_msb_q : b_msb_q;
        ovf_raw_s     = (a_msb_q == b_prime_msb_s) && (sum_msb_s != a_msb_q);
        slt_bit_s     = sum_msb_s ^ ovf_raw_s;
        nonzero_s     = nz_q | (|slice_sum_s);
    end

    // Controller next state, datapath updates and output register loads.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        acc_d      = acc_q;
        nz_d       = nz_q;
        result_d   = result_q;
        carryout_d = carryout_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = operand_a;
                    b_d     = operand_b;
                    a_msb_d = operand_a[WIDTH-1];
                    b_msb_d = operand_b[WIDTH-1];
                    cmd_d   = alu_cmd_e'(command);
                    cnt_d   = {CNT_W{1'b0}};
                    carry_d = is_sub_like(alu_cmd_e'(command));
                    acc_d   = {WIDTH{1'b0}};
                    nz_d    = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                carry_d = slice_cout_s;
                acc_d   = sum_full_s;
                nz_d    = nonzero_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SLICE) begin
                    state_d = DONE;
                    cnt_d   = {CNT_W{1'b0}};
                    if (cmd_q == CMD_SLT) begin
                        result_d   = WIDTH'(slt_bit_s);
                        zero_d     = ~slt_bit_s;
                        carryout_d = 1'b0;
                        overflow_d = 1'b0;
                    end else if (reports_flags(cmd_q)) begin
                        result_d   = sum_full_s;
                        zero_d     = ~nonzero_s;
                        carryout_d = slice_cout_s;
                        overflow_d = ovf_raw_s;
                    end else begin
                        result_d   = sum_full_s;
                        zero_d     = ~nonzero_s;
                        carryout_d = 1'b0;
                        overflow_d = 1'b0;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            cmd_q       <= CMD_ADD;
            cnt_q       <= {CNT_W{1'b0}};
            carry_q     <= 1'b0;
            acc_q       <= {WIDTH{1'b0}};
            nz_q        <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            carryout_q  <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            nz_q        <= nz_d;
            result_q    <= result_d;
            carryout_q  <= carryout_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign result    = result_q;
    assign carryout  = carryout_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: a 1-bit-slice instance (index 0) and an 8-bit-slice
// instance (index 1) driven by directed and random operations, checked
// against an arithmetic reference model.
module tb_alu_serial;
    import alu_defs::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] op_a      [2];
    logic [31:0] op_b      [2];
    logic [2:0]  cmd       [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] result    [2];
    logic        carryout  [2];
    logic        zero      [2];
    logic        overflow  [2];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    alu_serial #(.WIDTH(32), .SLICE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .operand_a(op_a[0]), .operand_b(op_b[0]), .command(cmd[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .result(result[0]), .carryout(carryout[0]), .zero(zero[0]), .overflow(overflow[0])
    );

    alu_serial #(.WIDTH(32), .SLICE(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .operand_a(op_a[1]), .operand_b(op_b[1]), .command(cmd[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .result(result[1]), .carryout(carryout[1]), .zero(zero[1]), .overflow(overflow[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {result, carryout, zero, overflow} from signed/unsigned arithmetic.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        longint      s;
        logic [32:0] w;
        logic [31:0] r;
        logic        co;
        logic        v;
        s  = 64'sd0;
        w  = 33'd0;
        r  = 32'd0;
        co = 1'b0;
        v  = 1'b0;
        case (c)
            3'd0: begin
                w  = {1'b0, a} + {1'b0, b};
                r  = w[31:0];
                co = w[32];
                s  = longint'($signed(a)) + longint'($signed(b));
                v  = (s != longint'($signed(r)));
            end
            3'd1: begin
                r  = a - b;
                co = (a >= b);
                s  = longint'($signed(a)) - longint'($signed(b));
                v  = (s != longint'($signed(r)));
            end
            3'd2: r = a ^ b;
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            3'd7: r = a | b;
            default: r = 32'd0;
        endcase
        return {r, co, (r == 32'd0), v};
    endfunction

    // Called at a negedge; presents a request and returns at the negedge after acceptance.
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        int t = 0;
        while (!req_ready[d] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("issue_ready", {31'd0, req_ready[d]}, 32'd1);
        op_a[d] = a;
        op_b[d] = b;
        cmd[d] = c;
        req_valid[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        op_a[d] = $urandom;
        op_b[d] = $urandom;
        cmd[d] = 3'($urandom);
    endtask

    task automatic wait_rsp(input int d);
        int e = 0;
        do begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end while (!rsp_valid[d] && e < 200);
        chk(d == 0 ? "latency_s1" : "latency_s8", e, (d == 0) ? 32'd32 : 32'd4);
    endtask

    task automatic check_rsp(input int d, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        logic [34:0] m;
        m = model(a, b, c);
        chk($sformatf("result d%0d cmd%0d a=%h b=%h", d, c, a, b), result[d], m[34:3]);
        chk($sformatf("carryout d%0d cmd%0d", d, c), {31'd0, carryout[d]}, {31'd0, m[2]});
        chk($sformatf("zero d%0d cmd%0d", d, c), {31'd0, zero[d]}, {31'd0, m[1]});
        chk($sformatf("overflow d%0d cmd%0d", d, c), {31'd0, overflow[d]}, {31'd0, m[0]});
    endtask

    task automatic release_rsp(input int d);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("released_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
        chk("released_req_ready", {31'd0, req_ready[d]}, 32'd1);
    endtask

    task automatic full_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        issue(d, a, b, c);
        wait_rsp(d);
        check_rsp(d, a, b, c);
        release_rsp(d);
    endtask

    // Hold DONE under a pending request, then let the pending request in.
    task automatic backpressure(input int d, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                                input logic [31:0] a2, input logic [31:0] b2, input logic [2:0] c2);
        logic [31:0] held_res;
        logic [2:0]  held_flags;
        issue(d, a, b, c);
        wait_rsp(d);
        check_rsp(d, a, b, c);
        held_res = result[d];
        held_flags = {carryout[d], zero[d], overflow[d]};
        op_a[d] = a2;
        op_b[d] = b2;
        cmd[d] = c2;
        req_valid[d] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_result_held", result[d], held_res);
            chk("bp_flags_held", {29'd0, carryout[d], zero[d], overflow[d]}, {29'd0, held_flags});
            chk("bp_req_ready", {31'd0, req_ready[d]}, 32'd0);
            chk("bp_rsp_valid", {31'd0, rsp_valid[d]}, 32'd1);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("bp_idle_req_ready", {31'd0, req_ready[d]}, 32'd1);
        chk("bp_idle_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        op_a[d] = $urandom;
        op_b[d] = $urandom;
        chk("bp_accepted", {31'd0, req_ready[d]}, 32'd0);
        wait_rsp(d);
        check_rsp(d, a2, b2, c2);
        release_rsp(d);
    endtask

    initial begin
        logic [31:0] dir_a   [15];
        logic [31:0] dir_b   [15];
        logic [2:0]  dir_c   [15];
        logic [31:0] dir_exp [15];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rc;

        dir_a   = '{32'd2, 32'd4, 32'd5, 32'd1, 32'h7FFFFFFF, 32'h80000000, 32'd5,
                    32'hFFFFFFFD, 32'h80000000, 32'd2,
                    32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
        dir_b   = '{32'd1, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd5,
                    32'd2, 32'd1, 32'hFFFFFFFD,
                    32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00};
        dir_c   = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3,
                    3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
        dir_exp = '{32'd3, 32'd2, 32'hFFFFFFFE, 32'd0, 32'h80000000, 32'h7FFFFFFF, 32'd0,
                    32'd1, 32'd1, 32'd0,
                    32'hF000F000, 32'h0FFF0FFF, 32'h000F000F, 32'hFFF0FFF0, 32'h0FF00FF0};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b0;
            op_a[d] = 32'd0;
            op_b[d] = 32'd0;
            cmd[d] = 3'd0;
        end
        #12;
        chk("reset_req_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("reset_result", result[0], 32'd0);
        chk("reset_flags", {29'd0, carryout[0], zero[0], overflow[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table on the 1-bit slice, with spec result constants as a second check.
        for (int i = 0; i < 15; i++) begin
            issue(0, dir_a[i], dir_b[i], dir_c[i]);
            wait_rsp(0);
            check_rsp(0, dir_a[i], dir_b[i], dir_c[i]);
            chk($sformatf("dir_result_%0d", i), result[0], dir_exp[i]);
            release_rsp(0);
            if (i == 0) begin
                // Reset in the middle of a new ADD, while the last result is still 3.
                issue(0, 32'd2, 32'd1, 3'd0);
                repeat (10) @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("midrst_req_ready", {31'd0, req_ready[0]}, 32'd1);
                chk("midrst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
                chk("midrst_result", result[0], 32'd0);
                chk("midrst_flags", {29'd0, carryout[0], zero[0], overflow[0]}, 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                full_op(0, 32'd9, 32'd6, 3'd1);
            end
        end

        backpressure(0, 32'd100, 32'd23, 3'd1, 32'h12345678, 32'h0F0F0F0F, 3'd0);

        // Random operations with a bias toward sign-boundary operands.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ra = {ra[31], 31'h7FFFFFFF};
            if ($urandom_range(0, 3) == 0) rb = ra;
            full_op(0, ra, rb, rc);
        end

        // 8-bit slice instance.
        backpressure(1, 32'h80000000, 32'd1, 3'd3, 32'h7FFFFFFF, 32'd1, 3'd0);
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 3'(i % 8);
            if (i == 3) rb = ra;
            full_op(1, ra, rb, rc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
